hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the 5-stage MIPS pipeline. It sits beside the IF/ID register. It tracks in-flight register writes in a small scoreboard with per-entry countdowns, and stalls decode until each source operand is available. Latencies are configurable, and the unit supports a no-forwarding mode, data-memory wait states, branch flush, and a saturating stall counter.

---
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: scoreboard of in-flight register writes with per-entry
// countdowns; stalls ID until source operands are available.
module hazard_scoreboard #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned WB_LAT   = 3,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned IF_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             control_flush,
    output logic             pc_freeze,
    output logic             IF_ID_freeze,
    output logic [IF_W-1:0]  in_flight,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned LAT_W = (WB_LAT > 0) ? $clog2(WB_LAT + 1) : 1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rg;
        logic [LAT_W-1:0] cnt;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [IF_W-1:0]  in_flight_q, in_flight_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [LAT_W-1:0] lat_c;
    logic             match_rs_c, match_rt_c, full_c, hazard_c;
    logic             issue_c, alloc_c, alloc_done;

    // Latency owed to a consumer directly behind the instruction in ID
    always_comb begin
        if (FWD_EN != 0) begin
            lat_c = id_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
        end else begin
            lat_c = LAT_W'(WB_LAT);
        end
    end

    always_comb begin
        match_rs_c = 1'b0;
        match_rt_c = 1'b0;
        full_c     = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (ent_q[i].rg == id_rs) match_rs_c = 1'b1;
                if (ent_q[i].rg == id_rt) match_rt_c = 1'b1;
            end else begin
                full_c = 1'b0;
            end
        end
        match_rs_c = match_rs_c && (id_rs != '0);
        match_rt_c = match_rt_c && (id_rt != '0);
    end

    assign hazard_c = id_valid && ((id_uses_rs && match_rs_c) || (id_uses_rt && match_rt_c) ||
                      (id_wr_en && (id_wr_reg != '0) && (lat_c != '0) && full_c));

    // mem_busy freezes everything; flush lets the redirect through
    always_comb begin
        control_flush = 1'b0;
        pc_freeze     = 1'b0;
        IF_ID_freeze  = 1'b0;
        if (mem_busy) begin
            pc_freeze    = 1'b1;
            IF_ID_freeze = 1'b1;
        end else if (!flush) begin
            control_flush = hazard_c;
            pc_freeze     = hazard_c;
            IF_ID_freeze  = hazard_c;
        end
    end

    assign issue_c = id_valid && !hazard_c && !flush && !mem_busy;
    assign alloc_c = issue_c && id_wr_en && (id_wr_reg != '0) && (lat_c != '0);

    // Free slots are chosen from pre-edge valid, so an entry retiring now is not reused
    always_comb begin
        alloc_done = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (!mem_busy && ent_q[i].valid) begin
                if (ent_q[i].cnt == LAT_W'(1)) ent_d[i].valid = 1'b0;
                ent_d[i].cnt = ent_q[i].cnt - LAT_W'(1);
            end
            if (alloc_c && !alloc_done && !ent_q[i].valid) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].rg    = id_wr_reg;
                ent_d[i].cnt   = lat_c;
                alloc_done     = 1'b1;
            end
        end
    end

    always_comb begin
        in_flight_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            in_flight_d = in_flight_d + IF_W'(ent_d[i].valid);
        end
        stall_d = (control_flush && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            in_flight_q <= '0;
            stall_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            in_flight_q <= in_flight_d;
            stall_q     <= stall_d;
        end
    end

    assign in_flight   = in_flight_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default-forwarding and no-forwarding (DEPTH=2) instances
// share stimulus and are checked every cycle against a slot-list model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, flush, mem_busy;
    logic [4:0] id_rs, id_rt, id_wr_reg;

    logic        cf0, pf0, ff0, cf1, pf1, ff1;
    logic [2:0]  if0;
    logic [1:0]  if1;
    logic [15:0] sc0, sc1;

    int checks = 0;
    int failures = 0;

    int m_cnt [2][4];
    int m_reg [2][4];
    int m_sc  [2];

    always #5 clk = ~clk;

    hazard_scoreboard u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy),
        .control_flush(cf0), .pc_freeze(pf0), .IF_ID_freeze(ff0), .in_flight(if0),
        .stall_count(sc0)
    );

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(0), .WB_LAT(3)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy),
        .control_flush(cf1), .pc_freeze(pf1), .IF_ID_freeze(ff1), .in_flight(if1),
        .stall_count(sc1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_depth(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int m_lat(input int i);
        if (i == 1) return 3;
        return id_is_load ? 1 : 0;
    endfunction

    function automatic int m_count(input int i);
        int n = 0;
        for (int j = 0; j < m_depth(i); j++) if (m_cnt[i][j] > 0) n++;
        return n;
    endfunction

    function automatic bit m_hit(input int i, input int r);
        if (r == 0) return 1'b0;
        for (int j = 0; j < m_depth(i); j++) if (m_cnt[i][j] > 0 && m_reg[i][j] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_hazard(input int i);
        return id_valid && ((id_uses_rs && m_hit(i, int'(id_rs))) ||
               (id_uses_rt && m_hit(i, int'(id_rt))) ||
               (id_wr_en && id_wr_reg != 0 && m_lat(i) != 0 && m_count(i) == m_depth(i)));
    endfunction

    function automatic bit m_cf(input int i);
        return !mem_busy && !flush && m_hazard(i);
    endfunction

    function automatic bit m_freeze(input int i);
        return mem_busy || (!flush && m_hazard(i));
    endfunction

    // Model state: counts owed per tracked write, advanced at each clock edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_sc[i] = 0;
                for (int j = 0; j < 4; j++) begin m_cnt[i][j] = 0; m_reg[i][j] = 0; end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit iss, al;
                int slot;
                slot = -1;
                iss = id_valid && !m_hazard(i) && !flush && !mem_busy;
                al  = iss && id_wr_en && id_wr_reg != 0 && m_lat(i) != 0;
                if (m_cf(i) && m_sc[i] < 65535) m_sc[i]++;
                for (int j = 0; j < m_depth(i); j++) if (slot < 0 && m_cnt[i][j] == 0) slot = j;
                if (!mem_busy)
                    for (int j = 0; j < m_depth(i); j++) if (m_cnt[i][j] > 0) m_cnt[i][j]--;
                if (al && slot >= 0) begin
                    m_cnt[i][slot] = m_lat(i);
                    m_reg[i][slot] = int'(id_wr_reg);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fwd_control_flush", int'(cf0), int'(m_cf(0)));
        chk("fwd_pc_freeze", int'(pf0), int'(m_freeze(0)));
        chk("fwd_IF_ID_freeze", int'(ff0), int'(m_freeze(0)));
        chk("fwd_in_flight", int'(if0), m_count(0));
        chk("fwd_stall_count", int'(sc0), m_sc[0]);
        chk("nofwd_control_flush", int'(cf1), int'(m_cf(1)));
        chk("nofwd_pc_freeze", int'(pf1), int'(m_freeze(1)));
        chk("nofwd_IF_ID_freeze", int'(ff1), int'(m_freeze(1)));
        chk("nofwd_in_flight", int'(if1), m_count(1));
        chk("nofwd_stall_count", int'(sc1), m_sc[1]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int v, input int rs, input int urs, input int rt, input int urt,
                          input int we, input int wr, input int ld, input int fl, input int mb);
        id_valid   = 1'(v);
        id_rs      = 5'(rs);
        id_uses_rs = 1'(urs);
        id_rt      = 5'(rt);
        id_uses_rt = 1'(urt);
        id_wr_en   = 1'(we);
        id_wr_reg  = 5'(wr);
        id_is_load = 1'(ld);
        flush      = 1'(fl);
        mem_busy   = 1'(mb);
    endtask

    task automatic idle_drain(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick;
    endtask

    // Holds the current ID instruction until the selected instance stops stalling
    task automatic count_stalls(input int inst, output int n);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!((inst == 0) ? cf0 : cf1)) break;
            n++;
            tick;
        end
        tick;
    endtask

    int n;

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_in_flight", int'(if0), 0);
        chk("reset_stall_count", int'(sc0), 0);
        chk("reset_control_flush", int'(cf0), 0);
        chk("reset_pc_freeze", int'(pf1), 0);
        tick;
        rst_n = 1'b1;

        // load-use with default latencies
        set_in(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick;
        set_in(1, 8, 1, 0, 0, 1, 10, 0, 0, 0);
        #1;
        chk("lu_control_flush", int'(cf0), 1);
        chk("lu_pc_freeze", int'(pf0), 1);
        chk("lu_IF_ID_freeze", int'(ff0), 1);
        tick;
        #1;
        chk("lu_release", int'(cf0), 0);
        tick;
        chk("lu_stall_count", int'(sc0), 1);
        idle_drain(5);

        // back-to-back ALU with forwarding
        set_in(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        tick;
        set_in(1, 8, 1, 0, 0, 1, 9, 0, 0, 0);
        #1;
        chk("alu_no_stall", int'(cf0), 0);
        chk("alu_in_flight", int'(if0), 0);
        tick;
        chk("alu_in_flight_after", int'(if0), 0);
        idle_drain(5);

        // no forwarding: write-back latency on rt, then r0 destination
        set_in(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        tick;
        set_in(1, 0, 0, 8, 1, 1, 11, 0, 0, 0);
        count_stalls(1, n);
        chk("nofwd_stalls", n, 3);
        idle_drain(5);
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick;
        set_in(1, 0, 0, 0, 1, 1, 12, 0, 0, 0);
        count_stalls(1, n);
        chk("nofwd_r0_stalls", n, 0);
        idle_drain(5);

        // mem_busy during load-use countdown
        set_in(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        tick;
        set_in(1, 9, 1, 0, 0, 1, 13, 0, 0, 1);
        #1;
        chk("mb_pc_freeze", int'(pf0), 1);
        chk("mb_control_flush", int'(cf0), 0);
        chk("mb_in_flight", int'(if0), 1);
        tick;
        #1;
        chk("mb_pc_freeze_2", int'(pf0), 1);
        chk("mb_control_flush_2", int'(cf0), 0);
        tick;
        mem_busy = 1'b0;
        #1;
        chk("mb_hazard_after", int'(cf0), 1);
        tick;
        #1;
        chk("mb_issue", int'(cf0), 0);
        tick;
        idle_drain(5);

        // full scoreboard, DEPTH=2 without forwarding
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick;
        set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        tick;
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        #1;
        chk("full_in_flight", int'(if1), 2);
        count_stalls(1, n);
        chk("full_stalls", n, 2);
        idle_drain(5);

        // flush during load-use stall
        set_in(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick;
        set_in(1, 8, 1, 0, 0, 1, 12, 1, 1, 0);
        #1;
        chk("fl_control_flush", int'(cf0), 0);
        chk("fl_pc_freeze", int'(pf0), 0);
        chk("fl_IF_ID_freeze", int'(ff0), 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_no_alloc", int'(if0), 0);
        chk("fl_stall_count", int'(sc0), 2);
        idle_drain(5);

        // asynchronous reset with two pending entries
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick;
        set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pending", int'(if1), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_in_flight", int'(if1), 0);
        chk("rst_async_stall_count", int'(sc1), 0);
        #2;
        rst_n = 1'b1;
        tick;
        set_in(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_no_stale_stall", int'(cf1), 0);
        tick;
        idle_drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
